multibyte_add_seq: RTL



---
 rtl/multibyte_add_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multibyte_add_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multibyte_add_seq : feeds an 8-bit ripple adder one byte per clock, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iStart,
  input  logic [8*NBYTES-1:0] iOp_a,
  input  logic [8*NBYTES-1:0] iOp_b,
  input  logic                iCin,
  output logic                oBusy,
  output logic                oDone,
  output logic [8*NBYTES-1:0] oSum,
  output logic                oCout,
  output logic [7:0]          oAdd_a,
  output logic [7:0]          oAdd_b,
  output logic                oAdd_c,
  input  logic [7:0]          iAdd_sum,
  input  logic                iAdd_c
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_last;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [W-1:0]    r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_done;
  logic            r_busy;

  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [W-1:0]    w_res_nxt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_last = (r_idx == c_LAST_IDX);
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Current byte selected by shifting the latched operand down by 8*idx.
  assign w_a_sh = r_a >> {r_idx, 3'b000};
  assign w_b_sh = r_b >> {r_idx, 3'b000};

  always_comb begin
    oAdd_a = 8'h00;
    oAdd_b = 8'h00;
    oAdd_c = 1'b0;
    if (r_state == S_RUN) begin
      oAdd_a = w_a_sh[7:0];
      oAdd_b = w_b_sh[7:0];
      oAdd_c = r_carry;
    end
  end

  // Final result must include the byte arriving on the completing edge.
  always_comb begin
    w_res_nxt = r_res;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IDXW'(k)) begin
        w_res_nxt[8*k +: 8] = iAdd_sum;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= iOp_a;
        r_b     <= iOp_b;
        r_carry <= iCin;
        r_idx   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_res   <= w_res_nxt;
        r_carry <= iAdd_c;
        r_idx   <= r_idx + IDXW'(1);
        if (w_last) begin
          r_sum  <= w_res_nxt;
          r_cout <= iAdd_c;
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_idx  <= '0;
        end
      end
    end
  end

  assign oBusy = r_busy;
  assign oDone = r_done;
  assign oSum  = r_sum;
  assign oCout = r_cout;

endmodule
`default_nettype wire
